// File: rtl/tri_sched.sv
// Round-robin scheduler sharing one triangle rasterizer among NREQ requesters (TRI_SCHED_FIXED_PRIO_EN selects fixed priority).
// Latency: handshake -> eng_nt next cycle, vertices on 3 consecutive cycles; engine points forwarded 1 cycle later.
// Backpressure: req_ready only in IDLE, one-hot to the arbitration winner; engine stalls hold WAIT/RUN indefinitely.
`timescale 1ns/1ps
module tri_sched #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*18-1:0] req_vtx,
  output logic               eng_nt,
  output logic [2:0]         eng_xi,
  output logic [2:0]         eng_yi,
  input  logic               eng_busy,
  input  logic               eng_po,
  input  logic [2:0]         eng_xo,
  input  logic [2:0]         eng_yo,
  output logic               pt_valid,
  output logic [2:0]         pt_x,
  output logic [2:0]         pt_y,
  output logic [TAGW-1:0]    pt_tag,
  output logic               job_done,
  output logic [TAGW-1:0]    done_tag,
  output logic [5:0]         done_cnt
);

  typedef struct packed {
    logic [2:0] x2;
    logic [2:0] y2;
    logic [2:0] x1;
    logic [2:0] y1;
    logic [2:0] x0;
    logic [2:0] y0;
  } tri_t;

  typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, WAIT, RUN, DONE} state_t;

  state_t          state, state_nxt;
  tri_t            tri_q;
  tri_t            sel_vtx;
  logic [TAGW-1:0] cur_tag;
  logic [5:0]      pt_cnt;
  logic [TAGW-1:0] grant_idx;
  logic [NREQ-1:0] grant;
  logic            any_vld;
  logic            fwd;

  assign any_vld = |req_valid;
  assign fwd     = ((state == WAIT) || (state == RUN)) && eng_po;

`ifdef TRI_SCHED_FIXED_PRIO_EN
  always_comb begin
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[i]) grant_idx = TAGW'(i);
  end
`else
  logic [TAGW-1:0] last_grant;
  logic            found;

  // Rotating search: the requester just after the last winner is tried first.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= NREQ; k++)
      for (int i = 0; i < NREQ; i++)
        if (!found && req_valid[i] && (((int'(last_grant) + k) % NREQ) == i)) begin
          found     = 1'b1;
          grant_idx = TAGW'(i);
        end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= TAGW'(NREQ - 1);
    else if (state == DONE)
      last_grant <= cur_tag;
  end
`endif

  assign grant = any_vld ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    sel_vtx = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) sel_vtx = req_vtx[i*18 +: 18];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tri_q    <= '0;
      cur_tag  <= '0;
      pt_cnt   <= '0;
      pt_valid <= 1'b0;
      pt_x     <= '0;
      pt_y     <= '0;
      pt_tag   <= '0;
    end else begin
      state    <= state_nxt;
      pt_valid <= fwd;
      if (state == IDLE && any_vld) begin
        tri_q   <= sel_vtx;
        cur_tag <= grant_idx;
        pt_cnt  <= '0;
      end
      if (fwd) begin
        pt_x   <= eng_xo;
        pt_y   <= eng_yo;
        pt_tag <= cur_tag;
        if (pt_cnt != 6'd63) pt_cnt <= pt_cnt + 6'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    eng_nt    = 1'b0;
    eng_xi    = '0;
    eng_yi    = '0;
    job_done  = 1'b0;
    done_tag  = '0;
    done_cnt  = '0;
    case (state)
      IDLE: begin
        // Gated by reset so no grant is visible while the block is held in reset.
        if (!reset) req_ready = grant;
        if (any_vld) state_nxt = SEND0;
      end
      SEND0: begin
        eng_nt    = 1'b1;
        eng_xi    = tri_q.x0;
        eng_yi    = tri_q.y0;
        state_nxt = SEND1;
      end
      SEND1: begin
        eng_xi    = tri_q.x1;
        eng_yi    = tri_q.y1;
        state_nxt = SEND2;
      end
      SEND2: begin
        eng_xi    = tri_q.x2;
        eng_yi    = tri_q.y2;
        state_nxt = WAIT;
      end
      WAIT: if (eng_busy) state_nxt = RUN;
      RUN:  if (!eng_busy) state_nxt = DONE;
      DONE: begin
        job_done  = 1'b1;
        done_tag  = cur_tag;
        done_cnt  = pt_cnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tri_sched.sv
// Directed bench for tri_sched: behavioural engine model, point/done monitor, hand-computed expectations.
// Grant-order expectations follow TRI_SCHED_FIXED_PRIO_EN when it is defined.
`timescale 1ns/1ps
module tb_tri_sched;
  localparam int NREQ = 4;
  localparam int TAGW = 2;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*18-1:0] req_vtx;
  logic               eng_nt;
  logic [2:0]         eng_xi, eng_yi;
  logic               eng_busy, eng_po;
  logic [2:0]         eng_xo, eng_yo;
  logic               pt_valid;
  logic [2:0]         pt_x, pt_y;
  logic [TAGW-1:0]    pt_tag;
  logic               job_done;
  logic [TAGW-1:0]    done_tag;
  logic [5:0]         done_cnt;

  tri_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vtx(req_vtx),
    .eng_nt(eng_nt), .eng_xi(eng_xi), .eng_yi(eng_yi),
    .eng_busy(eng_busy), .eng_po(eng_po), .eng_xo(eng_xo), .eng_yo(eng_yo),
    .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_tag(pt_tag),
    .job_done(job_done), .done_tag(done_tag), .done_cnt(done_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int eng_n = 0;
  bit spur_po = 0;
  bit idle_po = 0;
  int exp_tag = 0;
  logic [17:0] exp_vtx = '0;
  int pt_base = 0;
  int pt_total = 0;
  int last_pt_cyc = 0;
  int n_done = 0;
  int done_cyc = 0;
  int last_done_tag = 0;
  int last_done_cnt = 0;
  int exp_order[12];
  int left[NREQ];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] vtx_of(input int i);
    return 18'(i * 47293 + 9061);
  endfunction

  // Engine model: load 3 vertices after eng_nt, then busy with one point per cycle.
  initial begin
    eng_busy = 1'b0; eng_po = 1'b0; eng_xo = '0; eng_yo = '0;
    forever begin
      @(negedge clk);
      if (eng_nt && !reset) begin
        chk("v0", 32'({eng_xi, eng_yi}), 32'(exp_vtx[5:0]));
        @(negedge clk);
        chk("v1", 32'({eng_nt, eng_xi, eng_yi}), 32'({1'b0, exp_vtx[11:6]}));
        if (spur_po) begin
          eng_po = 1'b1; eng_xo = 3'd7; eng_yo = 3'd7;
        end
        @(negedge clk);
        chk("v2", 32'({eng_nt, eng_xi, eng_yi}), 32'({1'b0, exp_vtx[17:12]}));
        eng_po = 1'b0;
        @(negedge clk);
        chk("vtx_zero_wait", 32'({eng_nt, eng_xi, eng_yi}), 32'(0));
        for (int i = 0; i < eng_n && !reset; i++) begin
          eng_busy = 1'b1; eng_po = 1'b1;
          eng_xo = 3'(i); eng_yo = 3'(i + 5);
          @(negedge clk);
        end
        eng_busy = 1'b0; eng_po = 1'b0;
      end else begin
        eng_po = idle_po; eng_xo = 3'd5; eng_yo = 3'd5;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (pt_valid) begin
      chk("pt_tag", 32'(pt_tag), 32'(exp_tag));
      chk("pt_xy", 32'({pt_x, pt_y}), 32'({3'(pt_total - pt_base), 3'(pt_total - pt_base + 5)}));
      pt_total++;
      last_pt_cyc = cyc;
    end
    if (job_done) begin
      n_done++;
      done_cyc = cyc;
      last_done_tag = int'(done_tag);
      last_done_cnt = int'(done_cnt);
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'(0));
    chk({tag, "_eng"}, 32'({eng_nt, eng_xi, eng_yi}), 32'(0));
    chk({tag, "_pt"}, 32'({pt_valid, pt_x, pt_y, pt_tag}), 32'(0));
    chk({tag, "_done"}, 32'({job_done, done_tag, done_cnt}), 32'(0));
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int k = 0; k < budget && n_done == d0; k++) @(posedge clk);
    chk("done_seen", 32'(n_done != d0), 32'(1));
  endtask

  task automatic run_job(input int r, input logic [17:0] v, input int n, input bit spur, input int cnt_exp);
    int d0;
    @(negedge clk);
    req_vtx[r*18 +: 18] = v;
    req_valid = '0;
    req_valid[r] = 1'b1;
    eng_n = n; spur_po = spur; exp_tag = r; exp_vtx = v;
    pt_base = pt_total; d0 = n_done;
    #1 chk("grant", 32'(req_ready), 32'(1 << r));
    @(negedge clk);
    req_valid = '0;
    wait_done(d0, 400);
    chk("done_tag", 32'(last_done_tag), 32'(r));
    chk("done_cnt", 32'(last_done_cnt), 32'(cnt_exp));
    chk("pts", 32'(pt_total - pt_base), 32'(n));
    chk("pt_to_done", 32'(done_cyc - last_pt_cyc), 32'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int d0, d_start, grants, g, p0;
`ifdef TRI_SCHED_FIXED_PRIO_EN
    for (int j = 0; j < 12; j++) exp_order[j] = j / 3;
`else
    for (int j = 0; j < 12; j++) exp_order[j] = j % 4;
`endif
    reset = 1'b1; req_valid = '0; req_vtx = '0;
    repeat (2) @(negedge clk);
    req_valid = '1;
    #1 reset_checks("rst");
    @(negedge clk);
    req_valid = '0; reset = 1'b0;

    // Triangle (0,0),(3,0),(3,3) from requester 0, 10 points.
    run_job(0, {3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0}, 10, 1'b0, 10);

    // All requesters valid from reset, three jobs each.
    @(negedge clk);
    reset = 1'b1; req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_vtx[i*18 +: 18] = vtx_of(i);
      left[i] = 3;
    end
    #1 reset_checks("rst_rr");
    @(negedge clk);
    reset = 1'b0; eng_n = 2; spur_po = 1'b0;
    d_start = n_done; grants = 0;
    for (int guard = 0; guard < 3000 && grants < 12; guard++) begin
      #1;
      if (req_ready != '0) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        chk("rr_onehot", 32'($countones(req_ready)), 32'(1));
        chk("rr_order", 32'(g), 32'(exp_order[grants]));
        if (grants > 0) chk("idle_gap", 32'(cyc - done_cyc), 32'(1));
        exp_tag = g; exp_vtx = vtx_of(g); pt_base = pt_total;
        @(posedge clk);
        @(negedge clk);
        left[g]--;
        if (left[g] == 0) req_valid[g] = 1'b0;
        grants++;
      end else begin
        @(negedge clk);
      end
    end
    chk("rr_grants", 32'(grants), 32'(12));
    for (int k = 0; k < 500 && (n_done - d_start) < 12; k++) @(posedge clk);
    chk("rr_jobs", 32'(n_done - d_start), 32'(12));
    chk("rr_last_cnt", 32'(last_done_cnt), 32'(2));

    // Saturating point count.
    run_job(0, vtx_of(0), 70, 1'b0, 63);

    // eng_po while IDLE is ignored.
    @(negedge clk);
    p0 = pt_total;
    @(posedge clk) idle_po = 1'b1;
    @(posedge clk) idle_po = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_po", 32'(pt_total - p0), 32'(0));

    // eng_po during SEND1 is ignored.
    run_job(1, vtx_of(1), 3, 1'b1, 3);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    req_vtx[2*18 +: 18] = vtx_of(2);
    req_valid = 4'b0100; eng_n = 20; spur_po = 1'b0;
    exp_tag = 2; exp_vtx = vtx_of(2); pt_base = pt_total;
    @(negedge clk);
    req_valid = '0;
    repeat (8) @(negedge clk);
    chk("run_started", 32'((pt_total - pt_base) > 0), 32'(1));
    d0 = n_done;
    req_valid = '1;
    #2 reset = 1'b1;
    #1 reset_checks("rst_mid");
    repeat (3) @(negedge clk);
    chk("no_done_in_rst", 32'(n_done - d0), 32'(0));
    for (int i = 0; i < NREQ; i++) req_vtx[i*18 +: 18] = vtx_of(i);
    exp_tag = 0; exp_vtx = vtx_of(0); eng_n = 1; pt_base = pt_total;
    reset = 1'b0;
    #1 chk("post_rst_grant", 32'(req_ready), 32'(1));
    @(negedge clk);
    req_valid = '0;
    wait_done(d0, 100);
    chk("post_rst_tag", 32'(last_done_tag), 32'(0));
    chk("post_rst_cnt", 32'(last_done_cnt), 32'(1));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tri_sched.md
# tri_sched

Round-robin scheduler that shares one triangle rasterizer engine among NREQ requesters. Each requester submits a whole triangle (three 3-bit vertices) through a valid/ready handshake. The scheduler serialises the vertices into the engine's nt/xi/yi load protocol and forwards the engine's point stream back, tagged with the owning requester. It reports per-job completion with a point count. It sits between the client front-ends and the single rasterizer instance.

## Interface
- NREQ, 4: number of requesters, 2..8
- TAGW, 2: tag width, equal to clog2(NREQ)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester job valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_vtx  in  NREQ*18  per requester {x2,y2,x1,y1,x0,y0}, 3 bits each; requester i uses bits [18i+17:18i]
- eng_nt  out  1  new-triangle strobe to engine
- eng_xi, eng_yi  out  3 each  vertex to engine
- eng_busy  in  1  engine busy
- eng_po  in  1  engine point valid
- eng_xo, eng_yo  in  3 each  engine point
- pt_valid  out  1  forwarded point valid
- pt_x, pt_y  out  3 each  forwarded point
- pt_tag  out  TAGW  requester owning the point
- job_done  out  1  one-cycle completion pulse
- done_tag  out  TAGW  requester of the completed job
- done_cnt  out  6  points emitted by the job, saturating at 63

## Operation
- States: IDLE, SEND0, SEND1, SEND2, WAIT, RUN, DONE.
- **IDLE**
  - Arbiter picks a winner g among req_valid.
  - req_ready[g]=1 combinationally.
  - On the handshake: latch req_vtx[g] and cur_tag=g, clear pt_cnt, go to SEND0.
  - No valid: stay in IDLE, req_ready=0.
- **SEND0**: eng_nt=1, eng_xi/yi=x0/y0. **SEND1**: x1/y1. **SEND2**: x2/y2. eng_nt=0 in SEND1 and SEND2. Unconditional advance.
- **WAIT**: go to RUN when eng_busy=1. Forward points as in RUN.
- **RUN**: go to DONE on the first cycle with eng_busy=0.
- **DONE**
  - job_done=1, done_tag=cur_tag, done_cnt=pt_cnt.
  - Update the round-robin pointer to cur_tag, then go to IDLE.
- **Point forwarding** (WAIT and RUN only)
  - Registered, 1-cycle latency: pt_valid<=eng_po, pt_x/pt_y<=eng_xo/eng_yo, pt_tag<=cur_tag.
  - pt_cnt increments on each eng_po and holds at 63.
  - eng_po in any other state is ignored.
- **Round robin**
  - Search starts at last_grant+1 modulo NREQ.
  - Grant is one-hot.
  - A requester deasserting valid before ready receives no grant that cycle. No error is raised.
- **Protocol**
  - Requesters hold req_valid and req_vtx stable until ready.
  - Only one job is in the engine at a time. req_ready=0 in every state except IDLE.
- eng_xi/eng_yi are 0 outside the SEND states.
- Vertices pass unmodified. Degenerate triangles are the engine's concern.

## Timing
- **Reset values**
  - Outputs: req_ready=0, eng_nt=0, eng_xi=eng_yi=0, pt_valid=0, pt_x=pt_y=0, pt_tag=0, job_done=0, done_tag=0, done_cnt=0.
  - State IDLE; last_grant=NREQ-1, so requester 0 wins first.
- **Latency**: handshake at edge T gives eng_nt high in cycle T+1, v1 in T+2, v2 in T+3.
- **Minimum IDLE gap**: one cycle between job_done and the next req_ready.
- **Point and done ordering**
  - The final engine point (eng_po=1 with eng_busy=1) reaches pt_valid the cycle before job_done.
  - No pt_valid occurs after job_done for the same job.
- **Simultaneous requests**: exactly one grant per IDLE cycle. Losers keep valid and are served in rotation.
- **Reset mid-job**: all state is discarded and no job_done is issued. The engine is reset by the same reset.
- **Engine stall**: there is no timeout. WAIT and RUN last as long as the engine keeps busy high.

## Configuration
- Macro: TRI_SCHED_FIXED_PRIO_EN.
- Undefined (default): round-robin arbitration as above.
- Defined: fixed priority, where the lowest valid index always wins. The last_grant register is removed. All other behaviour and timing are unchanged.

## Test plan
- Single job, req 0 triangle (0,0),(3,0),(3,3) with an engine model producing 10 points:
  - eng_nt one cycle after the handshake, vertices on three consecutive cycles.
  - 10 pt_valid with pt_tag=0, then job_done with done_cnt=10.
- All four req_valid held high from reset, three jobs each:
  - Grants run 0,1,2,3,0,... in round-robin order.
  - With TRI_SCHED_FIXED_PRIO_EN, req 0's three jobs complete before req 1 is served.
- Engine model emitting 70 points: done_cnt=63 (saturated).
- Asynchronous reset asserted during RUN:
  - All outputs 0 immediately, no job_done.
  - After release, first grant goes to requester 0.
- eng_po pulsed while in IDLE and SEND1: no pt_valid, pt_cnt unchanged.
